// File: rtl/qpu_dtcm_arbt.sv
// ============================================================================
// Module      : qpu_dtcm_arbt
// Description : Two-master round-robin ICB arbiter in front of the QPU DTCM
//               controller, with an in-order ID FIFO for response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef QPU_DTCM_ADDR_WIDTH
`define QPU_DTCM_ADDR_WIDTH 16
`endif

module qpu_dtcm_arbt #(
    parameter int AW      = `QPU_DTCM_ADDR_WIDTH,
    parameter int DW      = 32,
    parameter int MW      = 4,
    parameter int OUTS_DP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          arbt_active,

    input  logic          m0_icb_cmd_valid,
    output logic          m0_icb_cmd_ready,
    input  logic [AW-1:0] m0_icb_cmd_addr,
    input  logic          m0_icb_cmd_read,
    input  logic [DW-1:0] m0_icb_cmd_wdata,
    input  logic [MW-1:0] m0_icb_cmd_wmask,
    output logic          m0_icb_rsp_valid,
    input  logic          m0_icb_rsp_ready,
    output logic [DW-1:0] m0_icb_rsp_rdata,

    input  logic          m1_icb_cmd_valid,
    output logic          m1_icb_cmd_ready,
    input  logic [AW-1:0] m1_icb_cmd_addr,
    input  logic          m1_icb_cmd_read,
    input  logic [DW-1:0] m1_icb_cmd_wdata,
    input  logic [MW-1:0] m1_icb_cmd_wmask,
    output logic          m1_icb_rsp_valid,
    input  logic          m1_icb_rsp_ready,
    output logic [DW-1:0] m1_icb_rsp_rdata,

    output logic          o_icb_cmd_valid,
    input  logic          o_icb_cmd_ready,
    output logic [AW-1:0] o_icb_cmd_addr,
    output logic          o_icb_cmd_read,
    output logic [DW-1:0] o_icb_cmd_wdata,
    output logic [MW-1:0] o_icb_cmd_wmask,
    input  logic          o_icb_rsp_valid,
    output logic          o_icb_rsp_ready,
    input  logic [DW-1:0] o_icb_rsp_rdata
);

    localparam int CW = $clog2(OUTS_DP + 1);
    localparam int PW = (OUTS_DP > 1) ? $clog2(OUTS_DP) : 1;
    localparam logic [CW-1:0] DEPTH    = CW'(OUTS_DP);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUTS_DP - 1);

    logic               rr_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [OUTS_DP-1:0] id_fifo;

    logic fifo_full;
    logic fifo_empty;
    logic gnt_vld;
    logic gnt_idx;
    logic head;
    logic cmd_hsk;
    logic rsp_hsk;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);

    // Grant is purely combinational; no lock is held across cycles.
    assign gnt_idx = (m0_icb_cmd_valid & m1_icb_cmd_valid) ? rr_ptr : m1_icb_cmd_valid;
    assign gnt_vld = (m0_icb_cmd_valid | m1_icb_cmd_valid) & ~fifo_full;

    assign o_icb_cmd_valid = gnt_vld;
    assign o_icb_cmd_addr  = gnt_idx ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign o_icb_cmd_read  = gnt_idx ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign o_icb_cmd_wdata = gnt_idx ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign o_icb_cmd_wmask = gnt_idx ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign m0_icb_cmd_ready = gnt_vld & ~gnt_idx & o_icb_cmd_ready;
    assign m1_icb_cmd_ready = gnt_vld &  gnt_idx & o_icb_cmd_ready;
    assign cmd_hsk          = gnt_vld & o_icb_cmd_ready;

    // Responses with an empty FIFO are stray and reach no master.
    assign head             = id_fifo[rd_ptr];
    assign m0_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty & ~head;
    assign m1_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty &  head;
    assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = o_icb_rsp_rdata;
    assign o_icb_rsp_ready  = (head ? m1_icb_rsp_ready : m0_icb_rsp_ready) & ~fifo_empty;
    assign rsp_hsk          = o_icb_rsp_valid & o_icb_rsp_ready;

    assign arbt_active = m0_icb_cmd_valid | m1_icb_cmd_valid | ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            id_fifo <= '0;
        end else begin
            if (cmd_hsk) begin
                id_fifo[wr_ptr] <= gnt_idx;
                wr_ptr          <= ptr_inc(wr_ptr);
                rr_ptr          <= ~gnt_idx;
            end
            if (rsp_hsk) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({cmd_hsk, rsp_hsk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/qpu_dtcm_arbt.md
# qpu_dtcm_arbt

Two-master ICB arbiter placed directly upstream of the QPU DTCM controller. It merges the LSU ICB port (master 0) and the measurement-result writer ICB port (master 1) into the single ICB command port of the DTCM controller. Arbitration is round-robin. Responses are returned in order to the issuing master through a small ID FIFO, so up to `OUTS_DP` transactions can be in flight.

## Interface
- `AW`, default `QPU_DTCM_ADDR_WIDTH`: byte-address width of all cmd channels.
- `DW`, default 32: data width.
- `MW`, default 4: write-mask width (DW/8).
- `OUTS_DP`, default 2: maximum outstanding transactions (ID FIFO depth, ≥1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `arbt_active` out 1: any master cmd valid, or any transaction outstanding. Feeds DTCM clock-gate logic.
- `m0_icb_cmd_valid/ready` in/out 1: LSU cmd handshake.
- `m0_icb_cmd_addr` in AW; `m0_icb_cmd_read` in 1; `m0_icb_cmd_wdata` in DW; `m0_icb_cmd_wmask` in MW: LSU cmd payload.
- `m0_icb_rsp_valid/ready` out/in 1; `m0_icb_rsp_rdata` out DW: LSU response.
- `m1_icb_*`: same set as m0, for the measurement-result writer.
- `o_icb_cmd_valid/ready` out/in 1; `o_icb_cmd_addr` out AW; `o_icb_cmd_read` out 1; `o_icb_cmd_wdata` out DW; `o_icb_cmd_wmask` out MW: to the DTCM controller.
- `o_icb_rsp_valid/ready` in/out 1; `o_icb_rsp_rdata` in DW: from the DTCM controller.

## Operation
State:
- `rr_ptr`: 1 bit. Index of the master that has priority on the next contention.
- ID FIFO: `OUTS_DP` entries of 1 bit, holding the master index. Has write/read pointers and a count of width clog2(`OUTS_DP`+1).

Grant:
- `fifo_full` = (count == `OUTS_DP`). While full, no grant is issued.
- When not full:
  - Only m0 valid: grant m0. Only m1 valid: grant m1.
  - Both valid: grant `rr_ptr`.
  - Neither valid: no grant.
- Grant is combinational and re-evaluated every cycle.
- A presented cmd may be withdrawn or swapped before it is accepted. The arbiter holds no lock.

Command path:
- `o_icb_cmd_valid` = granted master's valid. All payload fields mux from the granted master.
- Granted master's `cmd_ready` = `o_icb_cmd_ready` & !`fifo_full`. Non-granted master's `cmd_ready` = 0.
- On the cmd handshake (`o_icb_cmd_valid` & `o_icb_cmd_ready` & !`fifo_full`):
  - Push the granted index into the FIFO.
  - Set `rr_ptr` to the other master, regardless of whether contention occurred.

Response path:
- FIFO head selects the destination master.
- `mX_icb_rsp_valid` = `o_icb_rsp_valid` & !empty & (head == X). `mX_icb_rsp_rdata` = `o_icb_rsp_rdata`, unconditionally.
- `o_icb_rsp_ready` = destination master's `rsp_ready` & !empty.
- On the rsp handshake, pop the FIFO.
- `o_icb_rsp_valid` while the FIFO is empty is a protocol violation. It is ignored: no master sees valid and nothing pops.

Simultaneous events:
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full with a pop in the same cycle: no push that cycle. There is no full-bypass, so cmd_ready never depends on rsp_ready.

Pointers wrap modulo `OUTS_DP`.

## Timing
- Reset (`rst_n` low, asynchronous): `rr_ptr` = 0, FIFO pointers = 0, count = 0.
- Every output is combinational from inputs and these registers. Immediately after reset:
  - `o_icb_rsp_ready` = 0.
  - All `mX_icb_rsp_valid` = 0.
  - `mX_icb_cmd_ready` follows `o_icb_cmd_ready` for the granted master.
- Cmd latency: 0 cycles through the arbiter. Master cmd and `o_icb_cmd` handshake in the same cycle.
- Rsp latency: 0 cycles through the arbiter.
- Back-to-back: one cmd accepted per cycle while not full. Under continuous dual requests, grants alternate m0, m1, m0, … starting with m0 after reset.
- Reset mid-transaction: FIFO contents are discarded. A response arriving later with the FIFO empty is dropped per the rule above. The DTCM controller is reset by the same `rst_n`.
- No combinational path from `o_icb_rsp_valid` to any `cmd_ready`.

## Test plan
- **Single master.** Only m0 issues read A=0x10, then write A=0x14 with wdata 0xDEADBEEF, wmask 0xF, controller ready each cycle. Expect both cmds forwarded unchanged in consecutive cycles, both rsps on m0 in order, `m1_icb_rsp_valid` never 1.
- **Contention.** After reset, m0 and m1 both hold valid for 4 cycles with controller always ready. Expect accepted order m0, m1, m0, m1, and FIFO contents {0,1} at full with `OUTS_DP`=2 when responses are stalled.
- **Full.** With `OUTS_DP`=2, issue 2 cmds and hold `o_icb_rsp_valid`=0, then present a third cmd. Expect `cmd_ready`=0 for the third until the first rsp handshake, then accepted the following cycle.
- **Response back-pressure.** Head entry = m1, `o_icb_rsp_valid`=1, `m1_icb_rsp_ready`=0 for 3 cycles. Expect `o_icb_rsp_ready`=0 for those 3 cycles, rdata stable on m1, no pop, and m0 never sees rsp valid.
- **Simultaneous push/pop.** Count=1; in one cycle a new cmd handshake and a rsp handshake both occur. Expect count stays 1, head advances, and the new entry is correct.
- **Reset mid-flight.** With 2 outstanding, pulse `rst_n` low for 1 cycle. Expect count=0, `rr_ptr`=0, `arbt_active`=0 when no cmd valid, and a stray rsp is dropped.
